// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: forward-select encodings, hazard FSM states
// and the register-match helper used by the forwarding comparators.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MDU_WAIT = 2'd1,
        MEM_WAIT = 2'd2
    } hcState_t;

    typedef logic [1:0] fwdSel_t;

    localparam fwdSel_t FWD_REGFILE = 2'b00;
    localparam fwdSel_t FWD_WB      = 2'b01;
    localparam fwdSel_t FWD_MEM     = 2'b10;

    // A producer matches a consumer only if it writes, the indices agree, and
    // the index is not the hardwired zero register.
    function automatic logic srcHit(input logic idxEq, input logic regWrite,
                                    input logic idxZero, input logic x0Hw);
        return regWrite && idxEq && !(x0Hw && idxZero);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding-source selector for one E-stage source operand; M beats W.
module fwd_sel #(
    parameter int REG_AW       = 5,
    parameter int X0_HARDWIRED = 1
) (
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rdM,
    input  logic [REG_AW-1:0] rdW,
    input  logic              regWriteM,
    input  logic              regWriteW,
    output logic [1:0]        fwdSel
);
    import hazard_ctrl_pkg::*;

    logic srcZero;
    logic hitM;
    logic hitW;

    assign srcZero = (rsE == '0);
    assign hitM    = srcHit(rsE == rdM, regWriteM, srcZero, X0_HARDWIRED != 0);
    assign hitW    = srcHit(rsE == rdW, regWriteW, srcZero, X0_HARDWIRED != 0);

    always_comb begin
        fwdSel = FWD_REGFILE;
        if (hitM) begin
            fwdSel = FWD_MEM;
        end else if (hitW) begin
            fwdSel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use and branch hazards,
// multi-cycle MDU sequencing, data-memory wait stalls and a stall counter.
module hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int X0_HARDWIRED = 1,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              ResultSrcE_0,
    input  logic              PCSrcE,
    input  logic              MduOpE,
    input  logic              MduDone,
    input  logic              MemReqM,
    input  logic              MemReady,
    input  logic              PerfClr,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              FlushW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              MduGo,
    output logic              MduBusy,
    output logic [CNT_W-1:0]  StallCnt
);
    import hazard_ctrl_pkg::*;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    hcState_t          stateReg, stateNext;
    logic              doneLatchedReg, doneLatchedNext;
    logic [CNT_W-1:0]  stallCntReg;

    logic [REG_AW-1:0] rsE [2];
    logic [1:0]        fwd [2];

    logic memWait;
    logic lwStall;
    logic rdEZero;
    logic mduFinished;

    assign rsE[0] = Rs1E;
    assign rsE[1] = Rs2E;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gFwd
            fwd_sel #(
                .REG_AW       (REG_AW),
                .X0_HARDWIRED (X0_HARDWIRED)
            ) uFwdSel (
                .rsE       (rsE[gi]),
                .rdM       (RdM),
                .rdW       (RdW),
                .regWriteM (RegWriteM),
                .regWriteW (RegWriteW),
                .fwdSel    (fwd[gi])
            );
        end
    endgenerate

    assign ForwardAE = fwd[0];
    assign ForwardBE = fwd[1];

    assign memWait     = MemReqM && !MemReady;
    assign rdEZero     = (X0_HARDWIRED != 0) && (RdE == '0);
    assign lwStall     = ResultSrcE_0 && !rdEZero && ((RdE == Rs1D) || (RdE == Rs2D));
    assign mduFinished = MduDone || doneLatchedReg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg       <= IDLE;
            doneLatchedReg <= 1'b0;
        end else begin
            stateReg       <= stateNext;
            doneLatchedReg <= doneLatchedNext;
        end
    end

    always_comb begin
        stateNext       = stateReg;
        doneLatchedNext = doneLatchedReg;
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        FlushW = 1'b0;
        MduGo  = 1'b0;

        if (memWait) begin
            // Memory wait freezes F..M and bubbles W; an MDU in flight keeps
            // its state and remembers a completion that lands meanwhile.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
            if (stateReg == MDU_WAIT) begin
                doneLatchedNext = doneLatchedReg || MduDone;
            end else begin
                stateNext = MEM_WAIT;
            end
        end else begin
            case (stateReg)
                MDU_WAIT: begin
                    if (mduFinished) begin
                        stateNext       = IDLE;
                        doneLatchedNext = 1'b0;
                    end else begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        StallE = 1'b1;
                        FlushM = 1'b1;
                    end
                end
                default: begin
                    // IDLE, and MEM_WAIT once the memory has answered.
                    stateNext = IDLE;
                    if (MduOpE) begin
                        MduGo     = 1'b1;
                        StallF    = 1'b1;
                        StallD    = 1'b1;
                        StallE    = 1'b1;
                        FlushM    = 1'b1;
                        stateNext = MDU_WAIT;
                    end else if (PCSrcE) begin
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else if (lwStall) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                end
            endcase
        end

        if (reset) begin
            StallF = 1'b0;
            StallD = 1'b0;
            StallE = 1'b0;
            StallM = 1'b0;
            FlushD = 1'b0;
            FlushE = 1'b0;
            FlushM = 1'b0;
            FlushW = 1'b0;
            MduGo  = 1'b0;
        end
    end

    assign MduBusy = (stateReg == MDU_WAIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCntReg <= '0;
        end else if (PerfClr) begin
            stallCntReg <= '0;
        end else if (StallF && (stallCntReg != '1)) begin
            stallCntReg <= stallCntReg + CntOne;
        end
    end

    assign StallCnt = stallCntReg;

endmodule
